// File: rtl/npu_pkg.sv
// Shared types and helpers for the NPU result collector.
// FSM state encoding, output word count and byte saturation limits.
package npu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUANT = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int nw_f(
    input int n,
    input int dw,
    input int aw
  );
    return (n * dw + aw - 1) / aw;
  endfunction

  function automatic longint sat_hi(input int dw);
    return (longint'(1) << (dw - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/npu_requant.sv
// Requantise one signed accumulator: ReLU, round, shift, saturate.
// Ports: acc_i, shift_i, relu_en_i in; q_o out. Macro: NPU_RESULT_ROUND_EN.
module npu_requant
  import npu_pkg::*;
#(
  parameter int W_ACC      = 24,
  parameter int DATA_WIDTH = 8
) (
  input  logic [W_ACC-1:0]      acc_i,
  input  logic [4:0]            shift_i,
  input  logic                  relu_en_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  localparam int WE = W_ACC + 1;
  localparam logic signed [WE-1:0] HI =
    WE'(sat_hi(DATA_WIDTH));
  localparam logic signed [WE-1:0] LO =
    WE'(sat_lo(DATA_WIDTH));

  logic signed [WE-1:0] w_ext;
  logic signed [WE-1:0] w_add;
  logic signed [WE-1:0] w_sum;
  logic signed [WE-1:0] w_sh;

  always_comb begin
    w_ext = {acc_i[W_ACC-1], acc_i};
    if (relu_en_i && acc_i[W_ACC-1])
      w_ext = '0;
`ifdef NPU_RESULT_ROUND_EN
    // One extra bit keeps the rounding add from wrapping.
    if (shift_i == 5'd0)
      w_add = '0;
    else
      w_add = WE'(1) << (shift_i - 5'd1);
`else
    w_add = '0;
`endif
    w_sum = w_ext + w_add;
    w_sh  = w_sum >>> shift_i;
    if (w_sh > HI)
      q_o = HI[DATA_WIDTH-1:0];
    else if (w_sh < LO)
      q_o = LO[DATA_WIDTH-1:0];
    else
      q_o = w_sh[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/npu_result_collector.sv
// Captures N PE accumulators, requantises them to bytes and streams
// them out as AXI_WIDTH words with valid/ready/last.
// Ports: clk, rst_n, cap_i, results_i, shift_i, relu_en_i, clr_i in;
// out_valid_o/out_ready_i/out_data_o/out_last_o stream; busy_o, ovf_o.
// Macro: NPU_RESULT_ROUND_EN selects round-half-up instead of floor.
module npu_result_collector
  import npu_pkg::*;
#(
  parameter int N          = 10,
  parameter int W_ACC      = 24,
  parameter int DATA_WIDTH = 8,
  parameter int AXI_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cap_i,
  input  logic [N*W_ACC-1:0]   results_i,
  input  logic [4:0]           shift_i,
  input  logic                 relu_en_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [AXI_WIDTH-1:0] out_data_o,
  output logic                 out_last_o,
  output logic                 busy_o,
  output logic                 ovf_o,
  input  logic                 clr_i
);

  localparam int NW  = nw_f(N, DATA_WIDTH, AXI_WIDTH);
  localparam int WIW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [WIW-1:0] LASTW = WIW'(NW - 1);

  state_e                  r_state;
  logic [N*W_ACC-1:0]      r_res;
  logic [4:0]              r_shift;
  logic                    r_relu;
  logic [N*DATA_WIDTH-1:0] r_q;
  logic [WIW-1:0]          r_widx;
  logic                    r_ovf;

  logic [N*DATA_WIDTH-1:0]  w_q;
  logic [NW*AXI_WIDTH-1:0]  w_pad;
  logic [AXI_WIDTH-1:0]     w_word;
  logic                     w_valid;
  logic                     w_last;
  logic                     w_hs;

  for (genvar i = 0; i < N; i++) begin : g_rq
    npu_requant #(
      .W_ACC      (W_ACC),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_rq (
      .acc_i     (r_res[(i+1)*W_ACC-1 -: W_ACC]),
      .shift_i   (r_shift),
      .relu_en_i (r_relu),
      .q_o       (w_q[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Lanes past the last PE read as zero.
  always_comb begin
    w_pad = '0;
    w_pad[N*DATA_WIDTH-1:0] = r_q;
  end

  always_comb begin
    w_word = '0;
    for (int w = 0; w < NW; w++)
      if (r_widx == WIW'(w))
        w_word = w_pad[w*AXI_WIDTH +: AXI_WIDTH];
  end

  assign w_valid = (r_state == DRAIN);
  assign w_last  = w_valid && (r_widx == LASTW);
  assign w_hs    = w_valid && out_ready_i;

  assign out_valid_o = w_valid;
  assign out_last_o  = w_last;
  assign out_data_o  = w_valid ? w_word : '0;
  assign busy_o      = (r_state != IDLE);
  assign ovf_o       = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_res   <= '0;
      r_shift <= '0;
      r_relu  <= 1'b0;
      r_q     <= '0;
      r_widx  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      // A capture while busy wins over a clear.
      if (cap_i && (r_state != IDLE))
        r_ovf <= 1'b1;
      else if (clr_i)
        r_ovf <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (cap_i) begin
            r_res   <= results_i;
            r_shift <= shift_i;
            r_relu  <= relu_en_i;
            r_state <= QUANT;
          end
        end
        QUANT: begin
          r_q     <= w_q;
          r_widx  <= '0;
          r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_hs) begin
            if (w_last) begin
              r_widx  <= '0;
              r_state <= IDLE;
            end else begin
              r_widx <= r_widx + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_result_collector.sv
// Scoreboard bench for npu_result_collector.
// Stimulus pushes expected words; a negedge monitor pops and compares.
module tb_npu_result_collector;

  localparam int N  = 10;
  localparam int WA = 24;
  localparam int DW = 8;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cap_i = 1'b0;
  logic [N*WA-1:0] results_i = '0;
  logic [4:0]    shift_i = '0;
  logic          relu_en_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [AW-1:0] out_data_o;
  logic          out_last_o;
  logic          busy_o;
  logic          ovf_o;
  logic          clr_i = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  logic [AW:0] exp_q[$];

  always #5 clk = ~clk;

  npu_result_collector #(
    .N          (N),
    .W_ACC      (WA),
    .DATA_WIDTH (DW),
    .AXI_WIDTH  (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_i       (cap_i),
    .results_i   (results_i),
    .shift_i     (shift_i),
    .relu_en_i   (relu_en_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .ovf_o       (ovf_o),
    .clr_i       (clr_i)
  );

  task automatic chk(
    input string       nm,
    input logic [AW-1:0] act,
    input logic [AW-1:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL extra word: got %h want none",
                 out_data_o);
      end else begin
        logic [AW:0] e;
        e = exp_q.pop_front();
        chk("word data", out_data_o, e[AW-1:0]);
        chk("word last", AW'(out_last_o), AW'(e[AW]));
      end
    end
  end

  task automatic push3(
    input logic [AW-1:0] w0,
    input logic [AW-1:0] w1,
    input logic [AW-1:0] w2
  );
    exp_q.push_back({1'b0, w0});
    exp_q.push_back({1'b0, w1});
    exp_q.push_back({1'b1, w2});
  endtask

  task automatic set_pe(input int i, input int v);
    results_i[i*WA +: WA] = WA'(v);
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < N; i++) set_pe(i, v);
  endtask

  task automatic capture(input logic [4:0] sh, input logic relu);
    @(posedge clk); #1;
    shift_i   = sh;
    relu_en_i = relu;
    cap_i     = 1'b1;
    @(posedge clk); #1;
    cap_i = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy_o) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle timeout: busy %b want 0", busy_o);
    end
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_i = 1'b1;
    @(posedge clk); #1 clr_i = 1'b0;
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst valid", AW'(out_valid_o), 0);
    chk("rst data", out_data_o, 0);
    chk("rst last", AW'(out_last_o), 0);
    chk("rst busy", AW'(busy_o), 0);
    chk("rst ovf", AW'(ovf_o), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // All 256, shift 4, with latency check
    set_all(256);
    push3(32'h10101010, 32'h10101010, 32'h00001010);
    capture(5'd4, 1'b0);
    @(negedge clk);
    chk("lat quant valid", AW'(out_valid_o), 0);
    chk("lat quant busy", AW'(busy_o), 1);
    @(negedge clk);
    chk("lat first valid", AW'(out_valid_o), 1);
    wait_idle();

    // Rounding vs floor, positive and negative, saturation
    results_i = '0;
    set_pe(0, 24);
    set_pe(3, -24);
    set_pe(4, -1000);
    set_pe(9, 5000);
`ifdef NPU_RESULT_ROUND_EN
    push3(32'hFF000002, 32'h000000C2, 32'h00007F00);
`else
    push3(32'hFE000001, 32'h000000C1, 32'h00007F00);
`endif
    capture(5'd4, 1'b0);
    wait_idle();

    // Saturation, shift 0, without and with ReLU
    results_i = '0;
    set_pe(0, 32'h7FFFFF);
    set_pe(1, -1000);
    set_pe(2, -5);
    push3(32'h00FB807F, 32'h0, 32'h0);
    capture(5'd0, 1'b0);
    wait_idle();
    push3(32'h0000007F, 32'h0, 32'h0);
    capture(5'd0, 1'b1);
    wait_idle();

    // Maximum shift: rounding add must not wrap
    results_i = '0;
    set_pe(0, -1);
    set_pe(5, 32'h7FFFFF);
`ifdef NPU_RESULT_ROUND_EN
    push3(32'h0, 32'h00000100, 32'h0);
`else
    push3(32'h000000FF, 32'h0, 32'h0);
`endif
    capture(5'd23, 1'b0);
    wait_idle();

    // Back-pressure on word 1
    for (int i = 0; i < N; i++) set_pe(i, (i + 1) * 16);
    push3(32'h04030201, 32'h08070605, 32'h00000A09);
    capture(5'd4, 1'b0);
    @(posedge clk);
    @(posedge clk); #1 out_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall valid", AW'(out_valid_o), 1);
      chk("stall data", out_data_o, 32'h08070605);
      chk("stall last", AW'(out_last_o), 0);
    end
    @(posedge clk); #1 out_ready_i = 1'b1;
    wait_idle();

    // Capture during drain is ignored and flags overflow
    set_all(256);
    push3(32'h10101010, 32'h10101010, 32'h00001010);
    capture(5'd4, 1'b0);
    @(posedge clk); #1;
    set_all(48);
    cap_i = 1'b1;
    @(posedge clk); #1 cap_i = 1'b0;
    wait_idle();
    chk("ovf set", AW'(ovf_o), 1);
    pulse_clr();
    chk("ovf clr", AW'(ovf_o), 0);

    // Capture on the last handshake edge is ignored
    set_all(256);
    push3(32'h10101010, 32'h10101010, 32'h00001010);
    capture(5'd4, 1'b0);
    set_all(48);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1 cap_i = 1'b1;
    @(posedge clk); #1 cap_i = 1'b0;
    @(negedge clk);
    chk("last cap busy", AW'(busy_o), 0);
    chk("last cap ovf", AW'(ovf_o), 1);
    @(negedge clk);
    chk("last cap idle", AW'(out_valid_o), 0);
    pulse_clr();
    chk("ovf clr 2", AW'(ovf_o), 0);

    // Clear coinciding with overflow keeps the flag
    set_all(256);
    push3(32'h10101010, 32'h10101010, 32'h00001010);
    capture(5'd4, 1'b0);
    @(posedge clk); #1;
    cap_i = 1'b1;
    clr_i = 1'b1;
    @(posedge clk); #1;
    cap_i = 1'b0;
    clr_i = 1'b0;
    chk("ovf clr+set", AW'(ovf_o), 1);
    wait_idle();
    pulse_clr();

    // Reset mid-drain abandons the transfer
    set_all(256);
    push3(32'h10101010, 32'h10101010, 32'h00001010);
    capture(5'd4, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid rst valid", AW'(out_valid_o), 0);
    chk("mid rst data", out_data_o, 0);
    chk("mid rst last", AW'(out_last_o), 0);
    chk("mid rst busy", AW'(busy_o), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post rst valid", AW'(out_valid_o), 0);
    end

    chk("queue empty", AW'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
